// File: rtl/dram_wait_state_model_pkg.sv
// Shared definitions for the wait-state data memory model: FSM encoding,
// debug view and default bus widths.
package mem_pkg;

  localparam int DRAM_WORD_SIZE = 32;
  localparam int DRAM_ADDR_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } dram_state_t;

  typedef struct packed {
    dram_state_t state;
    logic        drive_en;
  } dram_dbg_t;

  function automatic int cnt_width(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/dram_wait_state_model_wait_state_counter.sv
// Loadable down-counter that stops at zero and flags it.
module wait_state_counter #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dram_wait_state_model.sv
// Word-addressed data memory answering ENABLE/READNOTWRITE requests after a
// fixed number of wait states, with a tristate data bus shared with the core.
module dram_wait_state_model
  import mem_pkg::*;
#(
  parameter int WORD_SIZE = DRAM_WORD_SIZE,
  parameter int ADDR_SIZE = DRAM_ADDR_SIZE,
  parameter int DEPTH     = 1024,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE-1:0] ADDRESS,
  input  logic                 ENABLE,
  input  logic                 READNOTWRITE,
  inout  wire  [WORD_SIZE-1:0] INOUT_DATA,
  output logic                 DATA_READY,
  output logic                 ADDR_ERROR,
  output dram_dbg_t            dbg
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = cnt_width(LATENCY);

  // Handshake: a request is taken when ENABLE is high at an edge in IDLE and
  // must stay high until DATA_READY is seen; dropping ENABLE before that
  // aborts it, dropping it in RESPOND completes it.

  dram_state_t            state;
  logic [IDX_W-1:0]       idx_q;
  logic                   rnw_q;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic                   oor_q;
  logic [WORD_SIZE-1:0]   rd_data;
  logic                   drive_en;
  logic [WORD_SIZE-1:0]   mem [DEPTH];

  logic [ADDR_SIZE-3:0]   req_idx;
  logic                   req_oor;
  logic                   cnt_zero;
  logic [CW-1:0]          cnt_val;
  logic                   commit;
  logic                   addr_unused;

  assign req_idx     = ADDRESS[ADDR_SIZE-1:2];
  assign req_oor     = (req_idx >= (ADDR_SIZE-2)'(DEPTH));
  assign addr_unused = &{1'b0, ADDRESS[1:0], cnt_val};
  assign commit      = (state == WAIT) && ENABLE && cnt_zero;

  wait_state_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     ((state == IDLE) && ENABLE),
    .load_val (CW'(LATENCY)),
    .dec      (state == WAIT),
    .count    (cnt_val),
    .zero     (cnt_zero)
  );

  // The array has no reset; gating on rst drops a write pending in WAIT.
  always_ff @(posedge clk) begin
    if (!rst && commit && !rnw_q && !oor_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Even LATENCY=0 passes through one WAIT cycle so DATA_READY always rises
  // after edge k+LATENCY+1 for a request sampled at edge k.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx_q      <= '0;
      rnw_q      <= 1'b1;
      wdata_q    <= '0;
      oor_q      <= 1'b0;
      rd_data    <= '0;
      drive_en   <= 1'b0;
      DATA_READY <= 1'b0;
      ADDR_ERROR <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ENABLE) begin
            idx_q   <= req_idx[IDX_W-1:0];
            rnw_q   <= READNOTWRITE;
            wdata_q <= INOUT_DATA;
            oor_q   <= req_oor;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (!ENABLE) begin
            state <= IDLE;
          end else if (cnt_zero) begin
            state      <= RESPOND;
            DATA_READY <= 1'b1;
            ADDR_ERROR <= oor_q;
            if (rnw_q) begin
              rd_data  <= oor_q ? '0 : mem[idx_q];
              drive_en <= 1'b1;
            end
          end
        end
        RESPOND: begin
          if (!ENABLE) begin
            state      <= IDLE;
            DATA_READY <= 1'b0;
            ADDR_ERROR <= 1'b0;
            drive_en   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign INOUT_DATA = drive_en ? rd_data : {WORD_SIZE{1'bz}};
  assign dbg        = '{state: state, drive_en: drive_en};

endmodule

// File: tb/tb_dram_wait_state_model.sv
// Bench for dram_wait_state_model: LATENCY=2 and LATENCY=0 instances driven
// by directed vectors, hand sequences and random traffic against a model.
module tb_dram_wait_state_model;
  import mem_pkg::*;

  localparam int LAT_A = 2;
  localparam int DEPTH = 1024;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance A: LATENCY=2
  logic [31:0] a_addr = '0;
  logic        a_en = 1'b0, a_rnw = 1'b1, a_wdrive = 1'b0;
  logic [31:0] a_wdata = '0;
  wire  [31:0] a_bus;
  logic        a_ready, a_err;
  dram_dbg_t   a_dbg;
  assign a_bus = a_wdrive ? a_wdata : 32'bz;

  dram_wait_state_model #(.WORD_SIZE(32), .ADDR_SIZE(32), .DEPTH(DEPTH), .LATENCY(LAT_A)) dut (
    .clk(clk), .rst(rst), .ADDRESS(a_addr), .ENABLE(a_en), .READNOTWRITE(a_rnw),
    .INOUT_DATA(a_bus), .DATA_READY(a_ready), .ADDR_ERROR(a_err), .dbg(a_dbg)
  );

  // instance B: LATENCY=0
  logic [31:0] b_addr = '0;
  logic        b_en = 1'b0, b_rnw = 1'b1, b_wdrive = 1'b0;
  logic [31:0] b_wdata = '0;
  wire  [31:0] b_bus;
  logic        b_ready, b_err;
  dram_dbg_t   b_dbg;
  assign b_bus = b_wdrive ? b_wdata : 32'bz;

  dram_wait_state_model #(.WORD_SIZE(32), .ADDR_SIZE(32), .DEPTH(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .ADDRESS(b_addr), .ENABLE(b_en), .READNOTWRITE(b_rnw),
    .INOUT_DATA(b_bus), .DATA_READY(b_ready), .ADDR_ERROR(b_err), .dbg(b_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: issue one request on instance A starting #1 after an edge in IDLE;
  // addr/data are swapped to *_after once the request has been sampled
  task automatic access(input logic rnw, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] addr_after, input logic [31:0] wd_after,
                        output logic [31:0] rd, output logic err, output int edges);
    a_addr = addr; a_rnw = rnw; a_wdata = wd; a_wdrive = !rnw; a_en = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        a_addr = addr_after; a_wdata = wd_after;
      end
    end while (!a_ready && edges < 30);
    rd  = a_bus;
    err = a_err;
    a_en = 1'b0; a_wdrive = 1'b0;
    @(posedge clk); #1;
  endtask

  // checked access; edges counts the accept edge, so ready after k+L+1 => L+2
  task automatic run_chk(input string name, input logic rnw, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] addr_after,
                         input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        err;
    int          edges;
    access(rnw, addr, wd, addr_after, wd ^ 32'hFFFF_FFFF, rd, err, edges);
    chk({name, ".latency"}, 32'(edges), 32'(LAT_A + 2));
    chk({name, ".err"}, {31'd0, err}, {31'd0, exp_err});
    if (rnw) chk({name, ".data"}, rd, exp_rd);
    chk({name, ".ready_released"}, {31'd0, a_ready}, 32'd0);
  endtask

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [int];

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h55AA_55AA, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_1000, 32'hCAFE_F00D, 32'h0, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_1000, 32'h0,         32'h0, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0000, 32'h0,         32'h55AA_55AA, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0FFC, 32'h1357_2468, 32'h0, 1'b0};
    vecs[7] = '{1'b1, 32'h0000_0FFF, 32'h0,         32'h1357_2468, 1'b0};
    vecs[8] = '{1'b0, 32'h0000_0042, 32'h0BAD_0080, 32'h0, 1'b0};
    vecs[9] = '{1'b1, 32'h0000_0040, 32'h0,         32'h0BAD_0080, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ready", {31'd0, a_ready}, 32'd0);
    chk("reset.err", {31'd0, a_err}, 32'd0);
    chk("reset.state", 32'(a_dbg.state), 32'(IDLE));
    chk("reset.drive", {31'd0, a_dbg.drive_en}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_chk($sformatf("vec%0d", i), vecs[i].rnw, vecs[i].addr, vecs[i].wdata,
              vecs[i].addr, vecs[i].exp_data, vecs[i].exp_err);
    end

    // reset mid-WAIT of a write to 0x10 discards it
    run_chk("rstw.base", 1'b0, 32'h10, 32'h1234_5678, 32'h10, 32'h0, 1'b0);
    a_addr = 32'h10; a_rnw = 1'b0; a_wdata = 32'hFFFF_0000; a_wdrive = 1'b1; a_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstw.in_wait", 32'(a_dbg.state), 32'(WAIT));
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("rstw.ready", {31'd0, a_ready}, 32'd0);
    chk("rstw.state", 32'(a_dbg.state), 32'(IDLE));
    chk("rstw.drive", {31'd0, a_dbg.drive_en}, 32'd0);
    rst = 1'b0; a_en = 1'b0; a_wdrive = 1'b0;
    @(posedge clk); #1;
    run_chk("rstw.readback", 1'b1, 32'h10, 32'h0, 32'h10, 32'h1234_5678, 1'b0);

    // abort: read 0x80 dropped after one wait cycle, then an aborted write
    run_chk("abort.base", 1'b0, 32'h80, 32'h0000_0080, 32'h80, 32'h0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      a_addr = 32'h80; a_rnw = (k == 0); a_wdata = 32'hBADB_AD00; a_wdrive = (k != 0); a_en = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      a_en = 1'b0; a_wdrive = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("abort%0d.state", k), 32'(a_dbg.state), 32'(IDLE));
      repeat (3) begin @(posedge clk); #1; end
      chk($sformatf("abort%0d.ready", k), {31'd0, a_ready}, 32'd0);
    end
    run_chk("abort.fresh_read", 1'b1, 32'h80, 32'h0, 32'h80, 32'h0000_0080, 1'b0);

    // address/data changes after acceptance are ignored
    run_chk("swap.w08", 1'b0, 32'h08, 32'h0808_0808, 32'h08, 32'h0, 1'b0);
    run_chk("swap.w0c", 1'b0, 32'h0C, 32'h0C0C_0C0C, 32'h0C, 32'h0, 1'b0);
    run_chk("swap.read", 1'b1, 32'h08, 32'h0, 32'h0C, 32'h0808_0808, 1'b0);
    run_chk("swap.write", 1'b0, 32'h0C, 32'h7777_0000, 32'h08, 32'h0, 1'b0);
    run_chk("swap.chk0c", 1'b1, 32'h0C, 32'h0, 32'h0C, 32'h7777_0000, 1'b0);
    run_chk("swap.chk08", 1'b1, 32'h08, 32'h0, 32'h08, 32'h0808_0808, 1'b0);

    // LATENCY=0 instance: ready one edge after accept, held while ENABLE high
    b_addr = 32'h04; b_rnw = 1'b0; b_wdata = 32'h0000_A5A5; b_wdrive = 1'b1; b_en = 1'b1;
    @(posedge clk); #1;
    chk("l0.w.accept", {31'd0, b_ready}, 32'd0);
    @(posedge clk); #1;
    chk("l0.w.ready", {31'd0, b_ready}, 32'd1);
    b_en = 1'b0; b_wdrive = 1'b0;
    @(posedge clk); #1;
    b_rnw = 1'b1; b_en = 1'b1;
    @(posedge clk); #1;
    chk("l0.r.accept", {31'd0, b_ready}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("l0.r.ready%0d", c), {31'd0, b_ready}, 32'd1);
      chk($sformatf("l0.r.data%0d", c), b_bus, 32'h0000_A5A5);
    end
    b_en = 1'b0;
    @(posedge clk); #1;
    chk("l0.r.fall", {31'd0, b_ready}, 32'd0);
    chk("l0.r.drive", {31'd0, b_dbg.drive_en}, 32'd0);

    // random traffic vs model, read expectations through exp_q
    ref_mem.delete();
    for (int n = 0; n < 60; n++) begin
      int          widx;
      logic        rnw;
      logic [31:0] wd, rd;
      logic        err;
      int          edges;
      widx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, DEPTH + 40))
                                         : int'($urandom_range(0, 15));
      rnw  = $urandom_range(0, 1) == 1;
      if (rnw && widx < DEPTH && !ref_mem.exists(widx)) rnw = 1'b0;
      wd = $urandom;
      if (rnw) exp_q.push_back((widx >= DEPTH) ? 32'h0 : ref_mem[widx]);
      else if (widx < DEPTH) ref_mem[widx] = wd;
      access(rnw, 32'(widx * 4 + int'($urandom_range(0, 3))), wd, 32'(widx * 4), wd, rd, err, edges);
      chk($sformatf("rnd%0d.latency", n), 32'(edges), 32'(LAT_A + 2));
      chk($sformatf("rnd%0d.err", n), {31'd0, err}, {31'd0, widx >= DEPTH});
      if (rnw) chk($sformatf("rnd%0d.data", n), rd, exp_q.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
